// File: rtl/q_sched_pkg.sv
// Shared types for the Q-learning update scheduler: FSM states and the latched transition record.
package q_sched_pkg;

    localparam int Q_W_DEF  = 32;
    localparam int TR_IDX_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE
    } sched_state_e;

    // Indices are held zero-extended so any table geometry up to 2^16 rows/columns fits.
    typedef struct packed {
        logic [TR_IDX_W-1:0] state;
        logic [TR_IDX_W-1:0] action;
        logic [TR_IDX_W-1:0] next_state;
        logic                terminal;
        logic [Q_W_DEF-1:0]  reward;
    } transition_t;

endpackage

// File: rtl/q_update_scheduler_q_table.sv
// Register-array Q-table: one write port, two combinational read ports (scan/current and host).
module q_table
    import q_sched_pkg::*;
#(
    parameter int NUM_STATES  = 16,
    parameter int NUM_ACTIONS = 4,
    parameter int Q_W         = Q_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [TR_IDX_W-1:0] wr_state,
    input  logic [TR_IDX_W-1:0] wr_action,
    input  logic [Q_W-1:0]      wr_data,
    input  logic [TR_IDX_W-1:0] ra_state,
    input  logic [TR_IDX_W-1:0] ra_action,
    output logic [Q_W-1:0]      ra_data,
    input  logic [TR_IDX_W-1:0] rb_state,
    input  logic [TR_IDX_W-1:0] rb_action,
    output logic [Q_W-1:0]      rb_data
);

    logic [Q_W-1:0] mem_q [NUM_STATES][NUM_ACTIONS];
    logic [Q_W-1:0] mem_d [NUM_STATES][NUM_ACTIONS];

    // Full-width index compares: out-of-range addresses match nothing, so reads give 0 and writes drop.
    always_comb begin
        mem_d   = mem_q;
        ra_data = '0;
        rb_data = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                if (we && wr_state == TR_IDX_W'(s) && wr_action == TR_IDX_W'(a))
                    mem_d[s][a] = wr_data;
                if (ra_state == TR_IDX_W'(s) && ra_action == TR_IDX_W'(a))
                    ra_data = mem_q[s][a];
                if (rb_state == TR_IDX_W'(s) && rb_action == TR_IDX_W'(a))
                    rb_data = mem_q[s][a];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STATES; s++)
                for (int a = 0; a < NUM_ACTIONS; a++)
                    mem_q[s][a] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/q_update_scheduler.sv
// Sequences one Q-learning update per accepted transition: scan max Q(s',.), drive the update
// datapath with held operands, wait its latency, then write the result back into Q(s,a).
module q_update_scheduler
    import q_sched_pkg::*;
#(
    parameter int NUM_STATES  = 16,
    parameter int NUM_ACTIONS = 4,
    parameter int DP_LAT      = 3,
    parameter int Q_W         = Q_W_DEF,
    localparam int SW = $clog2(NUM_STATES),
    localparam int AW = $clog2(NUM_ACTIONS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tr_valid,
    output logic          tr_ready,
    input  logic [SW-1:0] tr_state,
    input  logic [AW-1:0] tr_action,
    input  logic [SW-1:0] tr_next_state,
    input  logic          tr_terminal,
    input  logic [Q_W-1:0] tr_reward,
    input  logic [Q_W-1:0] cfg_alpha,
    input  logic [Q_W-1:0] cfg_gamma,
    output logic [Q_W-1:0] dp_current_q,
    output logic [Q_W-1:0] dp_reward,
    output logic [Q_W-1:0] dp_max_next_q,
    output logic [Q_W-1:0] dp_alpha,
    output logic [Q_W-1:0] dp_gamma,
    input  logic [Q_W-1:0] dp_result,
    output logic          upd_done,
    output logic [Q_W-1:0] upd_q,
    output logic          upd_err,
    input  logic [SW-1:0] rd_state,
    input  logic [AW-1:0] rd_action,
    output logic [Q_W-1:0] rd_q
);

    localparam int CW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    sched_state_e state_q, state_d;
    transition_t  tr_q, tr_d;
    logic [Q_W-1:0] alpha_q, alpha_d, gamma_q, gamma_d, max_q, max_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [Q_W-1:0] dp_cur_q, dp_cur_d, dp_rew_q, dp_rew_d, dp_max_q, dp_max_d;
    logic [Q_W-1:0] dp_alpha_q, dp_alpha_d, dp_gamma_q, dp_gamma_d;
    logic           upd_done_q, upd_done_d, upd_err_q, upd_err_d;
    logic [Q_W-1:0] upd_val_q, upd_val_d, rd_val_q, rd_val_d;

    logic [TR_IDX_W-1:0] ra_state, ra_action;
    logic [Q_W-1:0]      ra_data, rb_data;
    logic                tbl_we, accept, bad_s, bad_ns;

    assign tr_ready = rst_n && (state_q == ST_IDLE);
    assign accept   = tr_valid && tr_ready;
    assign bad_s    = 32'(tr_state) >= 32'(NUM_STATES);
    assign bad_ns   = 32'(tr_next_state) >= 32'(NUM_STATES);

    // Shared read port walks row s' during SCAN and fetches Q(s,a) during ISSUE.
    assign ra_state  = (state_q == ST_ISSUE) ? tr_q.state  : tr_q.next_state;
    assign ra_action = (state_q == ST_ISSUE) ? tr_q.action : TR_IDX_W'(idx_q);
    assign tbl_we    = (state_q == ST_WRITE);

    q_table #(
        .NUM_STATES (NUM_STATES),
        .NUM_ACTIONS(NUM_ACTIONS),
        .Q_W        (Q_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (tbl_we),
        .wr_state (tr_q.state),
        .wr_action(tr_q.action),
        .wr_data  (dp_result),
        .ra_state (ra_state),
        .ra_action(ra_action),
        .ra_data  (ra_data),
        .rb_state (TR_IDX_W'(rd_state)),
        .rb_action(TR_IDX_W'(rd_action)),
        .rb_data  (rb_data)
    );

    always_comb begin
        state_d    = state_q;
        tr_d       = tr_q;
        alpha_d    = alpha_q;
        gamma_d    = gamma_q;
        idx_d      = idx_q;
        max_d      = max_q;
        cnt_d      = cnt_q;
        dp_cur_d   = dp_cur_q;
        dp_rew_d   = dp_rew_q;
        dp_max_d   = dp_max_q;
        dp_alpha_d = dp_alpha_q;
        dp_gamma_d = dp_gamma_q;
        upd_val_d  = upd_val_q;
        upd_done_d = 1'b0;
        upd_err_d  = 1'b0;
        rd_val_d   = rb_data;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tr_d.state      = TR_IDX_W'(tr_state);
                    tr_d.action     = TR_IDX_W'(tr_action);
                    tr_d.next_state = TR_IDX_W'(tr_next_state);
                    tr_d.terminal   = tr_terminal;
                    tr_d.reward     = Q_W_DEF'(tr_reward);
                    alpha_d         = cfg_alpha;
                    gamma_d         = cfg_gamma;
                    max_d           = '0;
                    idx_d           = '0;
                    if (bad_s || (bad_ns && !tr_terminal))
                        upd_err_d = 1'b1;
                    else if (tr_terminal)
                        state_d = ST_ISSUE;
                    else
                        state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (ra_data > max_q)
                    max_d = ra_data;
                if (idx_q == AW'(NUM_ACTIONS - 1))
                    state_d = ST_ISSUE;
                else
                    idx_d = idx_q + 1'b1;
            end
            ST_ISSUE: begin
                dp_cur_d   = ra_data;
                dp_rew_d   = Q_W'(tr_q.reward);
                dp_max_d   = tr_q.terminal ? '0 : max_q;
                dp_alpha_d = alpha_q;
                dp_gamma_d = gamma_q;
                cnt_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CW'(DP_LAT - 1))
                    state_d = ST_WRITE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            ST_WRITE: begin
                upd_val_d  = dp_result;
                upd_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tr_q       <= '0;
            alpha_q    <= '0;
            gamma_q    <= '0;
            idx_q      <= '0;
            max_q      <= '0;
            cnt_q      <= '0;
            dp_cur_q   <= '0;
            dp_rew_q   <= '0;
            dp_max_q   <= '0;
            dp_alpha_q <= '0;
            dp_gamma_q <= '0;
            upd_val_q  <= '0;
            upd_done_q <= 1'b0;
            upd_err_q  <= 1'b0;
            rd_val_q   <= '0;
        end else begin
            state_q    <= state_d;
            tr_q       <= tr_d;
            alpha_q    <= alpha_d;
            gamma_q    <= gamma_d;
            idx_q      <= idx_d;
            max_q      <= max_d;
            cnt_q      <= cnt_d;
            dp_cur_q   <= dp_cur_d;
            dp_rew_q   <= dp_rew_d;
            dp_max_q   <= dp_max_d;
            dp_alpha_q <= dp_alpha_d;
            dp_gamma_q <= dp_gamma_d;
            upd_val_q  <= upd_val_d;
            upd_done_q <= upd_done_d;
            upd_err_q  <= upd_err_d;
            rd_val_q   <= rd_val_d;
        end
    end

    assign dp_current_q  = dp_cur_q;
    assign dp_reward     = dp_rew_q;
    assign dp_max_next_q = dp_max_q;
    assign dp_alpha      = dp_alpha_q;
    assign dp_gamma      = dp_gamma_q;
    assign upd_done      = upd_done_q;
    assign upd_q         = upd_val_q;
    assign upd_err       = upd_err_q;
    assign rd_q          = rd_val_q;

endmodule

// File: tb/tb_q_update_scheduler.sv
// Bench for q_update_scheduler with a 12-row table so that row indices 12..15 are out of range;
// a 3-stage update datapath model sits behind the dp_* ports.
module tb_q_update_scheduler;

    localparam int NS  = 12;
    localparam int NA  = 4;
    localparam int LAT = 3;
    localparam int QW  = 32;
    localparam int SW  = 4;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tr_valid;
    logic          tr_ready;
    logic [SW-1:0] tr_state, tr_next_state, rd_state;
    logic [AW-1:0] tr_action, rd_action;
    logic          tr_terminal;
    logic [QW-1:0] tr_reward, cfg_alpha, cfg_gamma;
    logic [QW-1:0] dp_current_q, dp_reward, dp_max_next_q, dp_alpha, dp_gamma, dp_result;
    logic          upd_done, upd_err;
    logic [QW-1:0] upd_q, rd_q;

    always #5 clk = ~clk;

    q_update_scheduler #(
        .NUM_STATES (NS),
        .NUM_ACTIONS(NA),
        .DP_LAT     (LAT),
        .Q_W        (QW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tr_valid     (tr_valid),
        .tr_ready     (tr_ready),
        .tr_state     (tr_state),
        .tr_action    (tr_action),
        .tr_next_state(tr_next_state),
        .tr_terminal  (tr_terminal),
        .tr_reward    (tr_reward),
        .cfg_alpha    (cfg_alpha),
        .cfg_gamma    (cfg_gamma),
        .dp_current_q (dp_current_q),
        .dp_reward    (dp_reward),
        .dp_max_next_q(dp_max_next_q),
        .dp_alpha     (dp_alpha),
        .dp_gamma     (dp_gamma),
        .dp_result    (dp_result),
        .upd_done     (upd_done),
        .upd_q        (upd_q),
        .upd_err      (upd_err),
        .rd_state     (rd_state),
        .rd_action    (rd_action),
        .rd_q         (rd_q)
    );

    // Update datapath: Q + alpha*(r + gamma*max - Q), modulo 2^QW, three register stages.
    function automatic logic [QW-1:0] dp_f(input logic [QW-1:0] cur, r, mx, al, ga);
        return cur + al * (r + ga * mx - cur);
    endfunction

    logic [QW-1:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= dp_f(dp_current_q, dp_reward, dp_max_next_q, dp_alpha, dp_gamma);
        p2 <= p1;
        p3 <= p2;
    end
    assign dp_result = p3;

    int n_tests = 0;
    int n_fail  = 0;
    logic [QW-1:0] qm [NS][NA];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++)
            for (int a = 0; a < NA; a++)
                qm[s][a] = '0;
    endtask

    // Reference: applies one transition to the model table and reports what the DUT should show.
    task automatic model_step(input int s, a, ns, input bit term, input logic [QW-1:0] r, al, ga,
                              output bit err, output logic [QW-1:0] q, output int lat);
        logic [QW-1:0] mx;
        err = (s >= NS) || (!term && ns >= NS);
        q   = '0;
        lat = 0;
        if (err) return;
        mx = '0;
        if (!term)
            for (int i = 0; i < NA; i++)
                if (qm[ns][i] > mx) mx = qm[ns][i];
        q   = dp_f(qm[s][a], r, mx, al, ga);
        qm[s][a] = q;
        lat = term ? LAT + 2 : NA + LAT + 2;
    endtask

    task automatic drive(input int s, a, ns, input bit term, input logic [QW-1:0] r, al, ga);
        tr_state      = SW'(s);
        tr_action     = AW'(a);
        tr_next_state = SW'(ns);
        tr_terminal   = term;
        tr_reward     = r;
        cfg_alpha     = al;
        cfg_gamma     = ga;
    endtask

    task automatic send(input int s, a, ns, input bit term, input logic [QW-1:0] r, al, ga);
        int k;
        drive(s, a, ns, term, r, al, ga);
        tr_valid = 1'b1;
        k = 0;
        while (!tr_ready && k < 40) begin
            tick();
            k++;
        end
        if (!tr_ready) chk("send_ready_timeout", tr_ready, 1);
        tick();
        tr_valid = 1'b0;
    endtask

    // Called just after the accept edge; returns cycles to upd_done and ready-while-busy count.
    task automatic wait_done(output int lat, output bit err, output int busy_ready);
        lat = -1;
        err = upd_err;
        busy_ready = 0;
        if (err) return;
        if (tr_ready) busy_ready++;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (upd_done) begin
                lat = k;
                return;
            end
            if (tr_ready) busy_ready++;
        end
    endtask

    task automatic read_all(input string tag);
        for (int s = 0; s < 16; s++) begin
            for (int a = 0; a < NA; a++) begin
                rd_state  = SW'(s);
                rd_action = AW'(a);
                tick();
                chk($sformatf("%s_rd_%0d_%0d", tag, s, a), rd_q, (s < NS) ? qm[s][a] : '0);
            end
        end
    endtask

    typedef struct {
        int            s, a, ns;
        bit            term;
        logic [QW-1:0] r, al, ga;
        bit            err;
        logic [QW-1:0] mx, cur, q;
        int            lat;
    } vec_t;

    function automatic vec_t mk(int s, a, ns, bit term, int r, al, ga, bit err, int mx, cur, q, lat);
        vec_t v;
        v.s = s; v.a = a; v.ns = ns; v.term = term;
        v.r = r; v.al = al; v.ga = ga; v.err = err;
        v.mx = mx; v.cur = cur; v.q = q; v.lat = lat;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[$];
        int lat, br, m_lat, cnt;
        bit err, m_err;
        logic [QW-1:0] m_q;
        int bs[20], ba[20], bns[20];
        bit bt[20];
        logic [QW-1:0] brw[20], bal[20], bga[20];

        vt.push_back(mk(2, 0, 0, 1, 5, 1, 1, 0, 0, 0, 5, 5));
        vt.push_back(mk(2, 1, 0, 1, 9, 1, 1, 0, 0, 0, 9, 5));
        vt.push_back(mk(2, 2, 0, 1, 3, 1, 1, 0, 0, 0, 3, 5));
        vt.push_back(mk(2, 3, 0, 1, 9, 1, 1, 0, 0, 0, 9, 5));
        vt.push_back(mk(0, 1, 2, 0, 10, 1, 1, 0, 9, 0, 19, 9));
        vt.push_back(mk(3, 0, 5, 1, 7, 1, 1, 0, 0, 0, 7, 5));
        vt.push_back(mk(1, 0, 0, 1, 4, 1, 1, 0, 0, 0, 4, 5));
        vt.push_back(mk(1, 2, 0, 1, 8, 1, 1, 0, 0, 0, 8, 5));
        vt.push_back(mk(1, 3, 0, 1, 1, 1, 1, 0, 0, 0, 1, 5));
        vt.push_back(mk(1, 2, 1, 0, 0, 1, 1, 0, 8, 8, 8, 9));
        vt.push_back(mk(12, 0, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(15, 1, 1, 1, 3, 1, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 13, 0, 3, 1, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(4, 3, 13, 1, 11, 1, 1, 0, 0, 0, 11, 5));
        vt.push_back(mk(0, 1, 2, 0, 1, 2, 3, 0, 9, 19, 37, 9));
        vt.push_back(mk(2, 2, 0, 0, 2, 3, 2, 0, 37, 3, 222, 9));

        rst_n = 1'b0;
        tr_valid = 1'b0;
        rd_state = '0;
        rd_action = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (3) tick();
        chk("rst_tr_ready", tr_ready, 0);
        chk("rst_upd_done", upd_done, 0);
        chk("rst_upd_err", upd_err, 0);
        chk("rst_upd_q", upd_q, 0);
        chk("rst_rd_q", rd_q, 0);
        chk("rst_dp_current_q", dp_current_q, 0);
        chk("rst_dp_max_next_q", dp_max_next_q, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_tr_ready", tr_ready, 1);
        read_all("init");

        foreach (vt[i]) begin
            send(vt[i].s, vt[i].a, vt[i].ns, vt[i].term, vt[i].r, vt[i].al, vt[i].ga);
            model_step(vt[i].s, vt[i].a, vt[i].ns, vt[i].term, vt[i].r, vt[i].al, vt[i].ga,
                       m_err, m_q, m_lat);
            wait_done(lat, err, br);
            chk($sformatf("v%0d_err", i), err, vt[i].err);
            if (!vt[i].err) begin
                chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
                chk($sformatf("v%0d_upd_q", i), upd_q, vt[i].q);
                chk($sformatf("v%0d_dp_max_next_q", i), dp_max_next_q, vt[i].mx);
                chk($sformatf("v%0d_dp_current_q", i), dp_current_q, vt[i].cur);
                chk($sformatf("v%0d_ready_busy", i), br, 0);
            end
        end
        read_all("table");

        // Host read of the entry being written returns the old value, then the new one.
        rd_state = 4'd1;
        rd_action = 2'd2;
        send(1, 2, 0, 1, 50, 1, 1);
        model_step(1, 2, 0, 1, 50, 1, 1, m_err, m_q, m_lat);
        wait_done(lat, err, br);
        chk("rbw_latency", lat, 5);
        chk("rbw_upd_q", upd_q, 50);
        chk("rbw_rd_old", rd_q, 8);
        tick();
        chk("rbw_rd_new", rd_q, 50);
        chk("upd_done_one_cycle", upd_done, 0);

        // Back-to-back random transitions with tr_valid held high.
        for (int n = 0; n < 20; n++) begin
            bs[n]  = ($urandom_range(0, 7) == 0) ? 12 + $urandom_range(0, 3) : $urandom_range(0, 3);
            ba[n]  = $urandom_range(0, NA - 1);
            bns[n] = ($urandom_range(0, 7) == 0) ? 12 + $urandom_range(0, 3) : $urandom_range(0, 3);
            bt[n]  = ($urandom_range(0, 3) == 0);
            brw[n] = $urandom_range(0, 500);
            bal[n] = $urandom_range(0, 3);
            bga[n] = $urandom_range(0, 3);
        end
        drive(bs[0], ba[0], bns[0], bt[0], brw[0], bal[0], bga[0]);
        tr_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            chk($sformatf("b2b%0d_ready", n), tr_ready, 1);
            tick();
            if (n < 19)
                drive(bs[n+1], ba[n+1], bns[n+1], bt[n+1], brw[n+1], bal[n+1], bga[n+1]);
            else
                tr_valid = 1'b0;
            model_step(bs[n], ba[n], bns[n], bt[n], brw[n], bal[n], bga[n], m_err, m_q, m_lat);
            wait_done(lat, err, br);
            chk($sformatf("b2b%0d_err", n), err, m_err);
            if (!m_err) begin
                chk($sformatf("b2b%0d_latency", n), lat, m_lat);
                chk($sformatf("b2b%0d_upd_q", n), upd_q, m_q);
                chk($sformatf("b2b%0d_ready_busy", n), br, 0);
            end
        end
        tick();
        read_all("b2b");

        // Reset during WAIT abandons the update and clears the table.
        send(0, 0, 1, 0, 99, 1, 1);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_tr_ready", tr_ready, 0);
        chk("midrst_dp_current_q", dp_current_q, 0);
        rst_n = 1'b1;
        tick();
        chk("midrst_idle_ready", tr_ready, 1);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (upd_done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        model_clear();
        read_all("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
